// File: rtl/tx_intf_pkg.sv
// tx_intf_pkg: shared state encoding and sizing helper for the TX stream slave
package tx_intf_pkg;
  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    INIT_COUNTER = 2'b01,
    RECV_STREAM  = 2'b10
  } state_t;
  function automatic int clogb2(input int v);
    int r;
    r = 0;
    for (int i = v - 1; i > 0; i = i >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/tx_intf_s_axis_fifo.sv
// tx_intf_s_axis_fifo: synchronous FWFT FIFO; writes become visible one cycle after they land
module tx_intf_s_axis_fifo
  import tx_intf_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 8192,
  parameter int CW    = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  din,
  input  logic          wr_en,
  output logic [W-1:0]  dout,
  input  logic          rd_en,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] rd_data_count
);
  localparam int AW = clogb2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, wr_vis, rd_ptr, occ, vis;
  logic wr, rd;
  assign occ   = wr_ptr - rd_ptr;
  assign vis   = wr_vis - rd_ptr;
  assign full  = occ == (AW+1)'(DEPTH);
  assign empty = vis == '0;
  assign wr    = wr_en & ~full;
  assign rd    = rd_en & ~empty;
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  // storage array, no reset needed since reads are gated by empty
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr[AW-1:0]] <= din;
  // pointers; wr_vis trails wr_ptr by one cycle to model the FWFT write latency
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr        <= '0;
      wr_vis        <= '0;
      rd_ptr        <= '0;
      rd_data_count <= '0;
    end else begin
      wr_ptr        <= wr ? wr_ptr + (AW+1)'(1) : wr_ptr;
      wr_vis        <= wr_ptr;
      rd_ptr        <= rd ? rd_ptr + (AW+1)'(1) : rd_ptr;
      rd_data_count <= CW'(occ);
    end
endmodule

// File: rtl/tx_intf_s_axis.sv
// tx_intf_s_axis: AXI-Stream slave filling an FWFT FIFO with armed, delayed, counted bursts
module tx_intf_s_axis
  import tx_intf_pkg::*;
#(
  parameter int WAIT_COUNT_BITS        = 5,
  parameter int MAX_NUM_DMA_SYMBOL     = 8192,
  parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
  parameter int C_S_AXIS_TDATA_WIDTH   = 64
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESET,
  input  logic                              endless_mode,
  input  logic [WAIT_COUNT_BITS-1:0]        START_COUNT_CFG,
  input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] S_AXIS_NUM_DMA_SYMBOL,
  input  logic                              start_1trans,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   DATA_TO_ACC,
  output logic                              EMPTYN_TO_ACC,
  input  logic                              ACC_ASK_DATA,
  output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] data_count,
  output logic                              trans_done,
  output logic                              tlast_err
);
  state_t state, state_nx;
  logic [WAIT_COUNT_BITS-1:0] count, count_nx;
  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] write_pointer;
  logic start_ff, arm, fifo_full, fifo_empty, acc, last_beat, xfer_end, err;
  logic tstrb_unused;
  assign tstrb_unused  = ^S_AXIS_TSTRB;
  assign arm           = start_1trans & ~start_ff;
  assign S_AXIS_TREADY = ~S_AXIS_ARESET & (state == RECV_STREAM) & ~fifo_full &
                         ((write_pointer <= S_AXIS_NUM_DMA_SYMBOL) | endless_mode);
  assign acc           = S_AXIS_TVALID & S_AXIS_TREADY;
  assign last_beat     = write_pointer == S_AXIS_NUM_DMA_SYMBOL;
  assign xfer_end      = acc & (S_AXIS_TLAST | (~endless_mode & last_beat));
  assign err           = acc & ~endless_mode &
                         (S_AXIS_TLAST ? (write_pointer < S_AXIS_NUM_DMA_SYMBOL) : last_beat);
  assign EMPTYN_TO_ACC = ~fifo_empty;
  // next state: arm wins from anywhere, then start delay, then burst until its end beat
  always_comb begin
    state_nx = state;
    count_nx = count;
    if (arm) begin
      state_nx = INIT_COUNTER;
      count_nx = '0;
    end else if (state == INIT_COUNTER) begin
      state_nx = (count == START_COUNT_CFG) ? RECV_STREAM : INIT_COUNTER;
      count_nx = (count == START_COUNT_CFG) ? '0 : count + WAIT_COUNT_BITS'(1);
    end else if (state == RECV_STREAM && xfer_end) begin
      state_nx = IDLE;
    end
  end
  // state, counters and the one-cycle status pulses
  always_ff @(posedge S_AXIS_ACLK)
    if (S_AXIS_ARESET) begin
      state         <= IDLE;
      count         <= '0;
      start_ff      <= 1'b0;
      write_pointer <= '0;
      trans_done    <= 1'b0;
      tlast_err     <= 1'b0;
    end else begin
      state         <= state_nx;
      count         <= count_nx;
      start_ff      <= start_1trans;
      write_pointer <= arm ? '0 : write_pointer + MAX_BIT_NUM_DMA_SYMBOL'(acc);
      trans_done    <= xfer_end;
      tlast_err     <= err;
    end
  tx_intf_s_axis_fifo #(
    .W    (C_S_AXIS_TDATA_WIDTH),
    .DEPTH(MAX_NUM_DMA_SYMBOL),
    .CW   (MAX_BIT_NUM_DMA_SYMBOL)
  ) u_fifo (
    .clk          (S_AXIS_ACLK),
    .rst          (S_AXIS_ARESET),
    .din          (S_AXIS_TDATA),
    .wr_en        (acc),
    .dout         (DATA_TO_ACC),
    .rd_en        (ACC_ASK_DATA),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .rd_data_count(data_count)
  );
endmodule

// File: tb/tb_tx_intf_s_axis.sv
// tb_tx_intf_s_axis: randomized bench with a queue-based behavioural model checked every cycle
module tb_tx_intf_s_axis;
  localparam int DEPTH = 16;
  logic clk = 0, rst = 1;
  logic endless_mode = 0, start_1trans = 0;
  logic [4:0] START_COUNT_CFG = 0;
  logic [13:0] S_AXIS_NUM_DMA_SYMBOL = 0;
  logic [63:0] S_AXIS_TDATA = 0;
  logic [7:0] S_AXIS_TSTRB = '1;
  logic S_AXIS_TLAST = 0, S_AXIS_TVALID = 0, S_AXIS_TREADY;
  logic [63:0] DATA_TO_ACC;
  logic EMPTYN_TO_ACC, ACC_ASK_DATA = 0;
  logic [13:0] data_count;
  logic trans_done, tlast_err;
  tx_intf_s_axis #(
    .WAIT_COUNT_BITS(5), .MAX_NUM_DMA_SYMBOL(DEPTH),
    .MAX_BIT_NUM_DMA_SYMBOL(14), .C_S_AXIS_TDATA_WIDTH(64)
  ) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .endless_mode(endless_mode),
    .START_COUNT_CFG(START_COUNT_CFG), .S_AXIS_NUM_DMA_SYMBOL(S_AXIS_NUM_DMA_SYMBOL),
    .start_1trans(start_1trans), .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB),
    .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
    .DATA_TO_ACC(DATA_TO_ACC), .EMPTYN_TO_ACC(EMPTYN_TO_ACC), .ACC_ASK_DATA(ACC_ASK_DATA),
    .data_count(data_count), .trans_done(trans_done), .tlast_err(tlast_err)
  );
  always #5 clk = ~clk;
  int checks = 0, passed = 0, pop_pct = 0;
  bit go = 0;
  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask
  // reference model: FIFO as a queue tagged with write cycle, transfer as arm time + beat tally
  logic [63:0] mq[$];
  int wq[$];
  int cyc = 0, m_start = 0, m_beats = 0, m_size_last = 0;
  bit m_act = 0, m_prev_start = 0, m_done = 0, m_err = 0;
  always @(negedge clk) if (go) begin
    bit rx, full, vis, rdy, acc, fin, bad;
    rx   = m_act && cyc >= m_start;
    full = mq.size() == DEPTH;
    vis  = mq.size() > 0 && wq[0] + 2 <= cyc;
    rdy  = !rst && rx && !full && (endless_mode || m_beats <= int'(S_AXIS_NUM_DMA_SYMBOL));
    chk("tready", S_AXIS_TREADY, rdy);
    chk("emptyn", EMPTYN_TO_ACC, vis);
    chk("data", DATA_TO_ACC, vis ? mq[0] : 64'h0);
    chk("data_count", data_count, m_size_last);
    chk("trans_done", trans_done, m_done);
    chk("tlast_err", tlast_err, m_err);
    acc = rdy && S_AXIS_TVALID;
    fin = acc && (S_AXIS_TLAST || (!endless_mode && m_beats == int'(S_AXIS_NUM_DMA_SYMBOL)));
    bad = acc && !endless_mode && (S_AXIS_TLAST ? m_beats < int'(S_AXIS_NUM_DMA_SYMBOL)
                                                : m_beats == int'(S_AXIS_NUM_DMA_SYMBOL));
    m_size_last = mq.size();
    if (rst) begin
      mq.delete(); wq.delete();
      m_act = 0; m_prev_start = 0; m_done = 0; m_err = 0; m_size_last = 0; m_beats = 0;
    end else begin
      if (ACC_ASK_DATA && vis) begin void'(mq.pop_front()); void'(wq.pop_front()); end
      if (acc) begin mq.push_back(S_AXIS_TDATA); wq.push_back(cyc); m_beats++; end
      m_done = fin;
      m_err  = bad;
      if (fin) m_act = 0;
      if (start_1trans && !m_prev_start) begin
        m_act = 1; m_start = cyc + int'(START_COUNT_CFG) + 2; m_beats = 0;
      end
      m_prev_start = start_1trans;
    end
    cyc++;
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic arm(input int cfg, input int num, input bit endl);
    START_COUNT_CFG = 5'(cfg); S_AXIS_NUM_DMA_SYMBOL = 14'(num); endless_mode = endl;
    S_AXIS_TVALID = 0; ACC_ASK_DATA = 0;
    start_1trans = 1; tick(); start_1trans = 0;
  endtask
  task automatic idle(input int n);
    S_AXIS_TVALID = 0;
    for (int c = 0; c < n; c++) begin
      ACC_ASK_DATA = $urandom_range(0, 99) < pop_pct;
      tick();
    end
    ACC_ASK_DATA = 0;
  endtask
  // offers up to n_max beats; returns two cycles after the last beat or the done pulse
  task automatic send(input int n_max, input int tlast_at, input int vpct, input int budget,
                      output int n_acc, output int n_done, output int n_err,
                      output int n_both, output int first);
    int k, tail;
    k = 0; tail = -1; n_done = 0; n_err = 0; n_both = 0; first = -1;
    for (int c = 0; c < budget; c++) begin
      S_AXIS_TVALID = k < n_max && $urandom_range(0, 99) < vpct;
      S_AXIS_TDATA  = {$urandom, $urandom};
      S_AXIS_TLAST  = (k + 1) == tlast_at;
      ACC_ASK_DATA  = $urandom_range(0, 99) < pop_pct;
      @(negedge clk);
      if (S_AXIS_TVALID && S_AXIS_TREADY) begin
        if (first < 0) first = c;
        k++;
      end
      n_done += int'(trans_done);
      n_err  += int'(tlast_err);
      n_both += int'(trans_done && tlast_err);
      tick();
      if (tail < 0 && (k == n_max || n_done > 0)) tail = 2;
      else if (tail > 0) tail--;
      if (tail == 0) break;
    end
    S_AXIS_TVALID = 0; S_AXIS_TLAST = 0; ACC_ASK_DATA = 0;
    n_acc = k;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int a, d, e, b, f;
    tick(); go = 1;
    tick(); tick();
    rst = 0;
    @(negedge clk);
    chk("reset_tready", S_AXIS_TREADY, 0);
    chk("reset_emptyn", EMPTYN_TO_ACC, 0);
    chk("reset_count", data_count, 0);
    chk("reset_done", trans_done, 0);
    tick();
    // basic burst
    pop_pct = 0;
    arm(3, 7, 0);
    send(10, 8, 100, 40, a, d, e, b, f);
    chk("basic_first_ready", f, 4);
    chk("basic_beats", a, 8);
    chk("basic_done", d, 1);
    chk("basic_err", e, 0);
    chk("basic_count", data_count, 8);
    pop_pct = 100; idle(30);
    // early TLAST
    pop_pct = 0;
    arm(1, 7, 0);
    send(6, 4, 100, 40, a, d, e, b, f);
    chk("early_beats", a, 4);
    chk("early_both", b, 1);
    chk("early_count", data_count, 4);
    pop_pct = 100; idle(30);
    // missing TLAST
    pop_pct = 0;
    arm(0, 3, 0);
    send(6, 0, 100, 40, a, d, e, b, f);
    chk("miss_beats", a, 4);
    chk("miss_err", e, 1);
    chk("miss_done", d, 1);
    S_AXIS_TVALID = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("miss_tready_low", S_AXIS_TREADY, 0); tick();
    end
    pop_pct = 100; idle(30);
    // full FIFO
    pop_pct = 0;
    arm(2, 31, 0);
    send(40, 0, 100, 40, a, d, e, b, f);
    chk("full_beats", a, 16);
    chk("full_count", data_count, 16);
    ACC_ASK_DATA = 1; tick(); tick(); ACC_ASK_DATA = 0;
    send(10, 0, 100, 10, a, d, e, b, f);
    chk("full_refill", a, 2);
    pop_pct = 60;
    send(14, 14, 80, 300, a, d, e, b, f);
    chk("full_rest", a, 14);
    chk("full_done", d, 1);
    chk("full_err", e, 0);
    pop_pct = 100; idle(30);
    // endless mode
    pop_pct = 50;
    arm(1, 3, 1);
    send(20, 20, 70, 300, a, d, e, b, f);
    chk("endless_beats", a, 20);
    chk("endless_done", d, 1);
    chk("endless_err", e, 0);
    pop_pct = 100; idle(40);
    // abort and re-arm
    pop_pct = 0;
    arm(1, 7, 0);
    send(5, 0, 100, 40, a, d, e, b, f);
    chk("abort_first", a, 5);
    arm(1, 7, 0);
    send(8, 8, 100, 40, a, d, e, b, f);
    chk("abort_beats", a, 8);
    chk("abort_done", d, 1);
    chk("abort_err", e, 0);
    chk("abort_count", data_count, 13);
    pop_pct = 100; idle(30);
    // reset mid-burst
    pop_pct = 0;
    arm(0, 7, 0);
    send(3, 0, 100, 20, a, d, e, b, f);
    S_AXIS_TVALID = 1; rst = 1;
    @(negedge clk);
    chk("rst_cycle_tready", S_AXIS_TREADY, 0);
    tick();
    rst = 0; S_AXIS_TVALID = 0;
    @(negedge clk);
    chk("post_rst_tready", S_AXIS_TREADY, 0);
    chk("post_rst_emptyn", EMPTYN_TO_ACC, 0);
    chk("post_rst_count", data_count, 0);
    tick();
    idle(3);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
